// File: rtl/fa_5bit.sv
// Parameterised ripple-carry adder with combinational and registered sum/carry outputs.
// Optional macro FA_OVF_EN adds signed-overflow outputs ovf (combinational) and ovf_q (registered).
module fa_5bit #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q
`ifdef FA_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
`ifdef FA_OVF_EN
  logic             w_c_msb;
`endif

  // One full-adder step of the chain.
  task automatic fa_bit(
    input  logic ai,
    input  logic bi,
    input  logic ci,
    output logic si,
    output logic co
  );
    si = ai ^ bi ^ ci;
    co = (ai & bi) | (ci & (ai ^ bi));
  endtask

  always_comb begin
    logic w_c;
    logic w_si;
    logic w_co;
    w_c   = cin;
    w_si  = 1'b0;
    w_co  = 1'b0;
    w_sum = '0;
`ifdef FA_OVF_EN
    w_c_msb = 1'b0;
`endif
    for (int i = 0; i < int'(WIDTH); i++) begin
`ifdef FA_OVF_EN
      // Carry into the sign bit feeds the overflow detector.
      if (i == int'(WIDTH) - 1) w_c_msb = w_c;
`endif
      fa_bit(a[i], b[i], w_c, w_si, w_co);
      w_sum[i] = w_si;
      w_c      = w_co;
    end
    w_cout = w_c;
  end

  assign s    = w_sum;
  assign cout = w_cout;
`ifdef FA_OVF_EN
  assign ovf  = w_c_msb ^ w_cout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
`ifdef FA_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      s_q    <= w_sum;
      cout_q <= w_cout;
`ifdef FA_OVF_EN
      ovf_q  <= ovf;
`endif
    end
  end

endmodule

// File: tb/tb_fa_5bit.sv
// Directed-vector, exhaustive and registered-path checks for fa_5bit (WIDTH=5).
module tb_fa_5bit;

  localparam int unsigned WIDTH = 5;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
`ifdef FA_OVF_EN
  logic             ovf;
  logic             ovf_q;
`endif

  int checks;
  int failures;

  fa_5bit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .s      (s),
    .cout   (cout),
    .s_q    (s_q),
    .cout_q (cout_q)
`ifdef FA_OVF_EN
    ,
    .ovf    (ovf),
    .ovf_q  (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [5:0] exp_sum;
    checks   = 0;
    failures = 0;

    vecs[0] = '{5'b10100, 5'b10010, 1'b0, 5'b00110, 1'b1};
    vecs[1] = '{5'b11010, 5'b00000, 1'b1, 5'b11011, 1'b0};
    vecs[2] = '{5'b11001, 5'b10001, 1'b1, 5'b01011, 1'b1};
    vecs[3] = '{5'b01100, 5'b00110, 1'b1, 5'b10011, 1'b0};
    vecs[4] = '{5'b11111, 5'b11111, 1'b1, 5'b11111, 1'b1};
    vecs[5] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0};
    vecs[6] = '{5'b00001, 5'b11111, 1'b0, 5'b00000, 1'b1};
    vecs[7] = '{5'b01010, 5'b00101, 1'b0, 5'b01111, 1'b0};

    // Reset held: registered outputs stay zero across clock edges.
    rst_n = 1'b0;
    a = 5'b10101; b = 5'b01011; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s_q", 32'(s_q), 32'd0);
    chk("reset_cout_q", 32'(cout_q), 32'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      #1;
      chk($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
    end

    // Exhaustive sweep against an arithmetic reference.
    for (int i = 0; i < 2048; i++) begin
      {a, b, cin} = 11'(i);
      #1;
      exp_sum = 6'(a) + 6'(b) + 6'(cin);
      chk($sformatf("sweep_%0d", i), 32'({cout, s}), 32'(exp_sum));
    end

    // Registered path: release reset, first edge loads the current sum.
    @(negedge clk);
    a = 5'b00110; b = 5'b00110; cin = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("pre_edge_s_q", 32'(s_q), 32'd0);
    @(posedge clk);
    #1;
    chk("reg_s_q", 32'(s_q), 32'b01101);
    chk("reg_cout_q", 32'(cout_q), 32'd0);

    // Input change between edges must not disturb s_q until the next edge.
    @(negedge clk);
    a = 5'b11111; b = 5'b11111; cin = 1'b1;
    #1;
    chk("hold_s_q", 32'(s_q), 32'b01101);
    @(posedge clk);
    #1;
    chk("reg2_s_q", 32'(s_q), 32'b11111);
    chk("reg2_cout_q", 32'(cout_q), 32'd1);

    // Mid-cycle reset clears at once.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_q", 32'(s_q), 32'd0);
    chk("async_rst_cout_q", 32'(cout_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FA_OVF_EN
    a = 5'b01111; b = 5'b00001; cin = 1'b0;
    #1;
    chk("ovf1_s", 32'(s), 32'b10000);
    chk("ovf1_ovf", 32'(ovf), 32'd1);
    @(posedge clk);
    #1;
    chk("ovf1_ovf_q", 32'(ovf_q), 32'd1);
    @(negedge clk);
    a = 5'b10000; b = 5'b11111; cin = 1'b0;
    #1;
    chk("ovf2_s", 32'(s), 32'b01111);
    chk("ovf2_cout", 32'(cout), 32'd1);
    chk("ovf2_ovf", 32'(ovf), 32'd1);
    a = 5'b00011; b = 5'b00001; cin = 1'b0;
    #1;
    chk("ovf3_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    chk("ovf3_ovf_q", 32'(ovf_q), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
